// File: rtl/cpu_pkg.sv
// Shared front-end constants and the fetch FSM state encoding.
package cpu_pkg;

    localparam int              XLEN        = 32;
    localparam logic [XLEN-1:0] RESET_PC    = 32'h0000_0000;
    localparam int              FETCH_DEPTH = 4;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: circular FIFO of {pc, inst} entries with a flush that empties it in one cycle.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited in-order requests into a prefetch buffer, with redirect/flush handling.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter int          DEPTH    = FETCH_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int              CW         = $clog2(DEPTH) + 1;
    localparam int              CRW        = CW + 1;
    localparam logic [XLEN-1:0] RESET_BASE = {RESET_PC[31:2], 2'b00};

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q;
    logic [XLEN-1:0]   resp_pc_q;
    logic [XLEN-1:0]   redirect_base;
    logic [CW-1:0]     outstanding_q;
    logic [CW-1:0]     outstanding_drained;
    logic [CW-1:0]     fifo_count;
    logic [CRW-1:0]    credit_used;
    logic              req_grant;
    logic              req_fire;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [2*XLEN-1:0] head;
    logic              unused_redirect_lsbs;

    assign redirect_base        = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign credit_used          = {1'b0, outstanding_q} + {1'b0, fifo_count};
    // Outstanding count assuming no request this cycle, which holds on redirect and in FLUSH.
    assign outstanding_drained  = outstanding_q - CW'(imem_resp_valid);

    always_comb begin
        state_d   = state_q;
        req_grant = 1'b0;
        push      = 1'b0;
        case (state_q)
            FETCH: begin
                req_grant = !redirect_valid && (credit_used < CRW'(DEPTH));
                push      = imem_resp_valid && !redirect_valid && !fifo_full;
                if (redirect_valid && outstanding_drained != '0) state_d = FLUSH;
            end
            FLUSH: begin
                if (!redirect_valid && outstanding_drained == '0) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    assign imem_req_valid = req_grant && !reset;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign inst_valid     = !reset && !fifo_empty;
    assign pop            = inst_valid && inst_ready;
    assign inst_pc        = inst_valid ? head[63:32] : RESET_PC;
    assign inst_data      = inst_valid ? head[31:0]  : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_BASE;
            resp_pc_q     <= RESET_BASE;
            outstanding_q <= '0;
        end else begin
            state_q <= state_d;
            case ({req_fire, imem_resp_valid})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: ;
            endcase
            if (redirect_valid) begin
                fetch_pc_q <= redirect_base;
                resp_pc_q  <= redirect_base;
            end else begin
                if (req_fire) fetch_pc_q <= fetch_pc_q + 32'd4;
                if (push)     resp_pc_q  <= resp_pc_q + 32'd4;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(2 * XLEN)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (push),
        .push_data({resp_pc_q, imem_resp_data}),
        .pop      (pop),
        .head_data(head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 4: prefetch buffer entries and max outstanding requests; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 imem_req_addr  output  32  byte address of the request; bits [1:0] always 0.
REQ-008 imem_resp_valid  input  1  one in-order response word this cycle.
REQ-009 imem_resp_data  input  32  instruction word.
REQ-010 inst_valid  output  1  buffered instruction available to decode.
REQ-011 inst_ready  input  1  decode consumes the instruction this cycle.
REQ-012 inst_data  output  32  instruction word at the buffer head.
REQ-013 inst_pc  output  32  address of inst_data.
REQ-014 redirect_valid  input  1  branch/jump redirect; highest priority.
REQ-015 redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0.

Function
REQ-016 A request transfers when imem_req_valid and imem_req_ready are both high; the response transfers when imem_resp_valid is high; an instruction transfers when inst_valid and inst_ready are both high.
REQ-017 The block SHALL keep a fetch PC, fetch_pc, that advances by 4 on each request transfer and wraps from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-018 imem_req_valid SHALL be high only in state FETCH when outstanding + count < DEPTH; imem_req_addr SHALL equal fetch_pc and stay stable while valid is high and ready is low.
REQ-019 The memory SHALL respond in order, no earlier than the cycle after the request transfer, with any latency; the outstanding counter increments on request transfer, decrements on response, and is unchanged when both occur.
REQ-020 In FETCH, each response SHALL be written to the buffer tail with its PC, taken from an in-order PC queue or from a response PC counter.
REQ-021 The buffer SHALL never overflow; a response arriving with count == DEPTH is a protocol violation that the credit rule in REQ-018 prevents.
REQ-022 inst_valid SHALL equal (count != 0); inst_data and inst_pc SHALL show the head entry combinationally from registered storage.
REQ-023 Buffer write and read in the same cycle SHALL leave count unchanged; with an empty buffer, the response becomes visible the next cycle (no bypass), so minimum fetch-to-decode latency is 2 cycles after the request transfer.
REQ-024 FSM states: FETCH, FLUSH.
REQ-025 FETCH to FLUSH: redirect_valid while outstanding is nonzero after this cycle's updates.
REQ-026 FETCH to FETCH (redirect): redirect_valid with no outstanding requests.
REQ-027 FLUSH to FETCH: the cycle outstanding reaches 0.
REQ-028 On any redirect_valid, the buffer SHALL be emptied; an inst transfer in the same cycle still completes; fetch_pc is loaded with {redirect_pc[31:2],2'b00}; no request is issued that cycle.
REQ-029 In FLUSH, responses SHALL be discarded, including any response coinciding with the redirect cycle, and no requests are issued.
REQ-030 A redirect in FLUSH SHALL overwrite fetch_pc and keep the state in FLUSH.

Reset
REQ-031 On reset: state=FETCH, fetch_pc=RESET_PC, count=0, outstanding=0.
REQ-032 During reset: imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=RESET_PC.
REQ-033 Reset asserted mid-operation SHALL abandon in-flight requests; the memory is reset with this block on the same clk/reset.
REQ-034 The first request SHALL be issued in the first cycle after reset deasserts.

Structure
REQ-035 Package cpu_pkg SHALL hold XLEN=32, RESET_PC, FETCH_DEPTH, and the fetch FSM state enum.
REQ-036 The buffer SHALL be a sub-module, fetch_fifo, with synchronous reset, push/pop and full/empty flags, and a 64-bit entry of {pc,inst}.

Verification
REQ-037 Reset, then zero-latency memory with ready=1 and inst_ready=1 -> requests at 0,4,8,... on consecutive cycles; inst_pc 0,4,8 with matching data; first inst_valid 2 cycles after the first request.
REQ-038 inst_ready=0, memory always ready, DEPTH=4 -> exactly 4 requests issued (0x0..0xC), then req_valid=0; inst_ready=1 then drains in order.
REQ-039 3-cycle response latency, redirect_pc=0x103 with 2 outstanding -> FLUSH; both responses dropped; next request addr 0x100; first inst_pc 0x100.
REQ-040 Redirect in the same cycle as a response and an inst transfer -> response dropped, head consumed, buffer empty next cycle.
REQ-041 RESET_PC=32'hFFFF_FFF8, memory always ready -> request addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-042 Reset asserted with 3 outstanding requests and a full buffer -> next cycle inst_valid=0, imem_req_valid=0; after deassert, fetch restarts at RESET_PC.
